// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: IF-stage program counter with branch redirect, stall and imem back-pressure handling
// Define BRANCH_PERF_CNT_EN to add redirect and stall-cycle counters.
module fetch_pc_ctrl #(
   parameter logic [31:0] PC_RESET    = 32'h0000_0000,
   parameter int unsigned INSTR_BYTES = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_PCSrc,
   input  logic [31:0] i_branch_target,
   input  logic        i_stall,
   input  logic        i_imem_ready,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic        o_imem_req,
   output logic        o_valid,
   output logic        o_flush_ifid,
   output logic        o_flush_idex,
   output logic        o_flush_exmem,
   output logic        o_misalign
`ifdef BRANCH_PERF_CNT_EN
   ,
   output logic [31:0] o_redirect_cnt,
   output logic [31:0] o_stall_cnt
`endif
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;
   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic        redirect;
   assign o_pc_plus4 = o_pc + 32'(INSTR_BYTES);
   // Everything handshake-related is gated by reset so a pending redirect never escapes.
   always_comb begin
      o_imem_req    = i_rst_n && state != S_IDLE;
      redirect      = o_imem_req && i_PCSrc;
      o_valid       = o_imem_req && !i_PCSrc && !i_stall && i_imem_ready;
      o_flush_ifid  = redirect;
      o_flush_idex  = redirect;
      o_flush_exmem = redirect;
      pc_nxt        = redirect ? {i_branch_target[31:2], 2'b00} : o_valid ? o_pc_plus4 : o_pc;
      state_nxt     = (state == S_IDLE || redirect || o_valid) ? S_FETCH :
                      (state == S_WAIT || (!i_stall && !i_imem_ready)) ? S_WAIT : S_FETCH;
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         o_pc       <= PC_RESET;
         o_misalign <= 1'b0;
      end else begin
         state      <= state_nxt;
         o_pc       <= pc_nxt;
         o_misalign <= redirect && |i_branch_target[1:0];
      end
   end
`ifdef BRANCH_PERF_CNT_EN
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_redirect_cnt <= '0;
         o_stall_cnt    <= '0;
      end else begin
         o_redirect_cnt <= o_redirect_cnt + 32'(redirect);
         o_stall_cnt    <= o_stall_cnt + 32'(o_imem_req && !o_valid && !redirect);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed and randomized checks of fetch_pc_ctrl against a cycle-level reference model
module tb_fetch_pc_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, pcsrc, stall, ready;
   logic [31:0] tgt;
   logic [31:0] o_pc, o_pc_plus4;
   logic        o_imem_req, o_valid, o_flush_ifid, o_flush_idex, o_flush_exmem, o_misalign;
`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] o_redirect_cnt, o_stall_cnt;
`endif
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] m_pc, m_rcnt, m_scnt;
   logic        m_active, m_mis;

   always #5 clk = ~clk;

   fetch_pc_ctrl #(.PC_RESET(32'h0000_0000), .INSTR_BYTES(4)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_PCSrc(pcsrc),
      .i_branch_target(tgt),
      .i_stall(stall),
      .i_imem_ready(ready),
      .o_pc(o_pc),
      .o_pc_plus4(o_pc_plus4),
      .o_imem_req(o_imem_req),
      .o_valid(o_valid),
      .o_flush_ifid(o_flush_ifid),
      .o_flush_idex(o_flush_idex),
      .o_flush_exmem(o_flush_exmem),
      .o_misalign(o_misalign)
`ifdef BRANCH_PERF_CNT_EN
      ,
      .o_redirect_cnt(o_redirect_cnt),
      .o_stall_cnt(o_stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_active = 1'b0; m_mis = 1'b0; m_rcnt = 32'h0; m_scnt = 32'h0;
   endtask

   // One cycle: drive at negedge, check outputs mid-cycle, then advance the model at the edge.
   task automatic cyc(input logic rn, input logic ps, input logic [31:0] tg, input logic st, input logic rd);
      logic e_req, e_redir, e_valid;
      @(negedge clk);
      rst_n = rn; pcsrc = ps; tgt = tg; stall = st; ready = rd;
      #1;
      n_vec++;
      e_req   = rn && m_active;
      e_redir = e_req && ps;
      e_valid = e_req && !ps && !st && rd;
      chk("pc", o_pc, m_pc);
      chk("pc_plus4", o_pc_plus4, m_pc + 32'd4);
      chk("imem_req", 32'(o_imem_req), 32'(e_req));
      chk("valid", 32'(o_valid), 32'(e_valid));
      chk("flush_ifid", 32'(o_flush_ifid), 32'(e_redir));
      chk("flush_idex", 32'(o_flush_idex), 32'(e_redir));
      chk("flush_exmem", 32'(o_flush_exmem), 32'(e_redir));
      chk("misalign", 32'(o_misalign), 32'(m_mis));
`ifdef BRANCH_PERF_CNT_EN
      chk("redirect_cnt", o_redirect_cnt, m_rcnt);
      chk("stall_cnt", o_stall_cnt, m_scnt);
`endif
      @(posedge clk);
      if (!rn) model_reset();
      else begin
         m_mis = e_redir && (tg[1:0] != 2'b00);
         if (!m_active) m_active = 1'b1;
         else if (e_redir) begin m_pc = tg & 32'hFFFF_FFFC; m_rcnt++; end
         else if (e_valid) m_pc = m_pc + 32'd4;
         else m_scnt++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; pcsrc = 1'b0; tgt = 32'h0; stall = 1'b0; ready = 1'b1;
      @(posedge clk);
      model_reset();
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      run(5);
      #1 chk("seq_pc", o_pc, 32'h10);
      cyc(1'b1, 1'b1, 32'h100, 1'b0, 1'b1);
      #1 chk("redir_pc", o_pc, 32'h100);
      run(1);
      #1 chk("after_redir_pc", o_pc, 32'h104);
      cyc(1'b1, 1'b1, 32'h20, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      #1 chk("stall_hold_pc", o_pc, 32'h20);
      run(1);
      #1 chk("stall_release_pc", o_pc, 32'h24);
      cyc(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
      #1 chk("stall_redir_pc", o_pc, 32'h200);
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      #1 chk("wait_hold_pc", o_pc, 32'h200);
      cyc(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
      #1 chk("wait_redir_pc", o_pc, 32'h40);
      run(1);
      cyc(1'b1, 1'b1, 32'h103, 1'b0, 1'b1);
      #1 chk("misalign_pc", o_pc, 32'h100);
      chk("misalign_pulse", 32'(o_misalign), 32'h1);
      run(1);
      #1 chk("misalign_clear", 32'(o_misalign), 32'h0);
      cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      #1 chk("wrap_plus4", o_pc_plus4, 32'h0);
      run(1);
      #1 chk("wrap_pc", o_pc, 32'h0);
      cyc(1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 32'h304, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h500, 1'b0, 1'b1);
      #1 chk("rst_redirect_pc", o_pc, 32'h0);
      run(1);
      cyc(1'b1, 1'b1, 32'h600, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 32'h700, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 32'h800, 1'b0, 1'b1);
`ifdef BRANCH_PERF_CNT_EN
      #1 chk("redirect_cnt3", o_redirect_cnt, 32'd3);
`endif
      #1 chk("latest_target_pc", o_pc, 32'h800);
      for (int i = 0; i < 600; i++)
         cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0), $urandom,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
